// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizes for the reorder buffer and the blocks around it.
//   ROB_WIDTH   : log2 of the ROB entry count (tag width)
//   REG_WIDTH   : architectural register index width
//   DATA_WIDTH  : result width carried on the CDB
//   cdb_t       : common data bus broadcast {valid, tag, data}
//   rob_entry_t : one ROB slot {done, has_dest, arch_num, data}
package reorder_buffer_pkg;

  localparam int ROB_WIDTH  = 3;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;

  typedef struct packed {
    logic                  done;
    logic                  has_dest;
    logic [REG_WIDTH-1:0]  arch_num;
    logic [DATA_WIDTH-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures CDB results,
// retires entries in program order and serves operands of finished but
// not yet committed instructions.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset (flushes ROB)
//   issue             : dispatch request; accepted when issue && issue_ready
//   issue_ready       : ROB not full (uses pre-retire occupancy)
//   issue_has_dest    : instruction writes an architectural register
//   issue_arch_num    : destination register index
//   issue_tag         : tag for the accepted issue (current tail)
//   cdb               : result broadcast {valid, tag, data}
//   read_tag[2]       : operand tags from the rename lookup
//   rob_read[2]       : {valid = result available, tag = read_tag, data}
//   retire            : head entry leaves this cycle
//   commit            : retire with a destination register
//   commit_arch_num   : head destination index
//   commit_tag        : head index
//   commit_data       : head result
//
// Handshake: an issue transfers on a clock edge where issue && issue_ready
// are both high; issue_ready does not depend on issue or on retire.
module reorder_buffer #(
  parameter int ROB_WIDTH = reorder_buffer_pkg::ROB_WIDTH,
  parameter int REG_WIDTH = reorder_buffer_pkg::REG_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue,
  output logic                          issue_ready,
  input  logic                          issue_has_dest,
  input  logic [REG_WIDTH-1:0]          issue_arch_num,
  output logic [ROB_WIDTH-1:0]          issue_tag,
  input  reorder_buffer_pkg::cdb_t      cdb,
  input  logic [ROB_WIDTH-1:0]          read_tag [2],
  output reorder_buffer_pkg::cdb_t      rob_read [2],
  output logic                          retire,
  output logic                          commit,
  output logic [REG_WIDTH-1:0]          commit_arch_num,
  output logic [ROB_WIDTH-1:0]          commit_tag,
  output logic [31:0]                   commit_data
);

  localparam int DEPTH = 1 << ROB_WIDTH;

  logic [ROB_WIDTH-1:0]           head;
  logic [ROB_WIDTH-1:0]           tail;
  logic [ROB_WIDTH:0]             count;
  reorder_buffer_pkg::rob_entry_t entries [DEPTH];

  logic empty;
  logic full;
  logic issue_fire;

  assign empty       = (count == '0);
  // count only reaches its top bit when every slot is occupied
  assign full        = count[ROB_WIDTH];
  assign issue_ready = !full;
  assign issue_fire  = issue && !full;
  assign issue_tag   = tail;

  assign retire          = !empty && entries[head].done;
  assign commit          = retire && entries[head].has_dest;
  assign commit_arch_num = entries[head].arch_num;
  assign commit_tag      = head;
  assign commit_data     = entries[head].data;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].done <= 1'b0;
      end
    end else begin
      // Clearing done on retire keeps a freed slot from looking finished.
      if (retire) begin
        entries[head].done <= 1'b0;
        head               <= head + ROB_WIDTH'(1);
      end
      if (issue_fire) begin
        entries[tail].done     <= 1'b0;
        entries[tail].has_dest <= issue_has_dest;
        entries[tail].arch_num <= issue_arch_num;
        tail                   <= tail + ROB_WIDTH'(1);
      end
      // The CDB only targets allocated slots, so it never collides with the
      // tail slot being allocated or the head slot being freed.
      if (cdb.valid) begin
        entries[cdb.tag].done <= 1'b1;
        entries[cdb.tag].data <= cdb.data;
      end
      case ({issue_fire, retire})
        2'b10:   count <= count + (ROB_WIDTH+1)'(1);
        2'b01:   count <= count - (ROB_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Operand read: a result on the CDB this cycle wins over the stored entry.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rob_read[i].tag = read_tag[i];
      if (cdb.valid && (cdb.tag == read_tag[i])) begin
        rob_read[i].valid = 1'b1;
        rob_read[i].data  = cdb.data;
      end else begin
        rob_read[i].valid = entries[read_tag[i]].done;
        rob_read[i].data  = entries[read_tag[i]].data;
      end
    end
  end

endmodule
